// File: rtl/aes_subbytes_unit.sv
// AES SubBytes over a multi-byte word, NUM_SBOX bytes per clock, forward or inverse S-box.
// The S-box is computed algebraically (GF(2^8) inverse plus affine map), so there are no lookup ROMs.
module aes_subbytes_unit #(
  parameter int WORD_BYTES = 16,
  parameter int NUM_SBOX   = 4,
  parameter int INV_EN     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*WORD_BYTES-1:0] in_data,
  input  logic                    in_inv,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic                    busy
);
  localparam int P     = WORD_BYTES / NUM_SBOX;
  localparam int CNT_W = (P > 1) ? $clog2(P) : 1;
  localparam int BIT_W = (WORD_BYTES > 1) ? $clog2(8 * WORD_BYTES) : 3;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(P - 1);

  if (NUM_SBOX < 1 || NUM_SBOX > WORD_BYTES || (WORD_BYTES % NUM_SBOX) != 0) begin : g_bad_cfg
    $error("aes_subbytes_unit: NUM_SBOX must divide WORD_BYTES and lie in 1..WORD_BYTES");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          pass_cnt;
  logic [8*WORD_BYTES-1:0]   work;
  logic [8*WORD_BYTES-1:0]   out_q;
  logic [8*WORD_BYTES-1:0]   next_work;
  logic                      mode;
  logic                      accept;
  logic [7:0]                lane_in  [NUM_SBOX];
  logic [7:0]                lane_out [NUM_SBOX];
  logic [BIT_W-1:0]          lane_pos [NUM_SBOX];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
  endfunction

  // Handshake: a word moves on a rising edge where valid and ready are both high; the
  // producer holds valid and data steady until that edge, and ready never depends on valid.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = out_q;

  always_comb begin
    for (int j = 0; j < NUM_SBOX; j++) begin
      lane_pos[j] = BIT_W'((int'(pass_cnt) * NUM_SBOX + j) * 8);
      lane_in[j]  = work[lane_pos[j] +: 8];
    end
  end

  always_comb begin
    next_work = work;
    for (int j = 0; j < NUM_SBOX; j++) begin
      next_work[lane_pos[j] +: 8] = lane_out[j];
    end
  end

  for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
    if (INV_EN != 0) begin : g_both
      assign lane_out[j] = mode ? inv_sbox(lane_in[j]) : fwd_sbox(lane_in[j]);
    end else begin : g_fwd
      assign lane_out[j] = fwd_sbox(lane_in[j]);
    end
  end

  // out_q only moves on RUN->DONE, so it keeps the last finished word while a new one runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pass_cnt <= '0;
      work     <= '0;
      out_q    <= '0;
      mode     <= 1'b0;
    end else if (accept) begin
      work     <= in_data;
      mode     <= (INV_EN != 0) && in_inv;
      pass_cnt <= '0;
      state    <= RUN;
    end else begin
      case (state)
        RUN: begin
          work <= next_work;
          if (pass_cnt == LAST_PASS) begin
            pass_cnt <= '0;
            out_q    <= next_work;
            state    <= DONE;
          end else begin
            pass_cnt <= pass_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/aes_subbytes_unit.md
AES_SUBBYTES_UNIT -- requirements
Module: aes_subbytes_unit

Interface
REQ-001 SHALL provide parameter WORD_BYTES, default 16, meaning the number of bytes per word.
REQ-002 SHALL provide parameter NUM_SBOX, default 4, meaning the number of S-box lanes used per cycle.
REQ-003 SHALL provide parameter INV_EN, default 1, meaning 1 enables the inverse S-box mode and 0 builds forward-only.
REQ-004 SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-005 SHALL provide port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL provide port in_valid, input, 1 bit: in_data and in_inv are offered.
REQ-008 SHALL provide port in_ready, output, 1 bit: the unit accepts a word this cycle.
REQ-009 SHALL provide port in_data, input, 8*WORD_BYTES bits: byte i is bits [8i+7:8i].
REQ-010 SHALL provide port in_inv, input, 1 bit: 1 selects inverse S-box; it is ignored when INV_EN=0.
REQ-011 SHALL provide port out_valid, output, 1 bit: out_data holds a completed word.
REQ-012 SHALL provide port out_ready, input, 1 bit: the consumer accepts out_data.
REQ-013 SHALL provide port out_data, output, 8*WORD_BYTES bits: substituted word, in the same byte order as in_data.
REQ-014 SHALL provide port busy, output, 1 bit: high in states RUN and DONE.

Function
REQ-015 SHALL fail elaboration unless 1 <= NUM_SBOX <= WORD_BYTES and WORD_BYTES mod NUM_SBOX == 0.
REQ-016 SHALL define P = WORD_BYTES/NUM_SBOX as the number of substitution passes per word.
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready), combinationally from state and out_ready.
REQ-019 SHALL perform a handshake on a rising edge where in_valid and in_ready are both 1: capture in_data into the working register, latch the mode (in_inv and INV_EN), clear the pass counter, and go to RUN.
REQ-020 SHALL, on each RUN edge with pass counter k, replace bytes k*NUM_SBOX .. k*NUM_SBOX+NUM_SBOX-1 of the working register with their S-box images and increment k.
REQ-021 SHALL, on the RUN edge where k==P-1, complete the last pass and go to DONE; when P=1 this is the first RUN edge.
REQ-022 SHALL produce outputs that match the FIPS-197 forward S-box when the latched mode is 0, and the FIPS-197 inverse S-box when it is 1.
REQ-023 SHALL use an S-box datapath that is purely combinational and adds no cycles.
REQ-024 SHALL raise out_valid exactly P clock edges after the accepting edge; for the defaults, acceptance at edge E0 gives out_valid high after edge E4.
REQ-025 SHALL assert out_valid only in DONE, with out_data equal to the working register and held stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, in DONE with out_ready=1 and in_valid=0, return to IDLE and deassert out_valid on that edge.
REQ-027 SHALL, in DONE with out_ready=1 and in_valid=1, both retire the current word and accept the new one on the same edge, going directly to RUN (back-to-back throughput is one word per P+1 cycles).
REQ-028 SHALL ignore in_data and in_inv changes after acceptance; the latched mode applies to all P passes.
REQ-029 SHALL keep out_data stable in IDLE and RUN, holding the last retired word or the reset value.
REQ-030 SHALL wrap the pass counter only through the RUN->DONE transition, with width clog2(P), minimum 1 bit.
REQ-031 SHALL, when INV_EN=0, contain no inverse S-box logic and always use forward mode.

Reset
REQ-032 SHALL, while rst_n=0, force state=IDLE, pass counter=0, working register/out_data=0, latched mode=0, out_valid=0 and busy=0, with in_ready=1.
REQ-033 SHALL, when reset asserts mid-RUN or in DONE, clear the state immediately without waiting for a clock, discard the word in flight, and never emit it.
REQ-034 SHALL resume normal operation on the first rising edge after rst_n deasserts; the environment SHALL NOT assert in_valid during reset.

Verification
REQ-035 The bench SHALL cover: defaults, in_data all bytes 0x00, in_inv=0, accepted at E0 -> out_valid after E4, all out_data bytes 0x63, busy high for E1..E4.
REQ-036 The bench SHALL cover: defaults, in_inv=1, bytes 0x63,0x16,0xED,0x00 repeated -> out_data bytes 0x00,0xFF,0x53,0x52 repeated.
REQ-037 The bench SHALL cover: WORD_BYTES=16, NUM_SBOX=16, byte i=i, in_inv=0 -> out_valid after one edge, byte0=0x63, byte1=0x7C, byte15=0x76.
REQ-038 The bench SHALL cover: out_ready held 0 for 10 cycles in DONE -> out_data and out_valid stable; then out_ready=1 with in_valid=1 -> retire and accept on the same edge, next out_valid P edges later.
REQ-039 The bench SHALL cover: rst_n pulsed low after the 2nd RUN edge -> out_valid=0, busy=0, out_data=0 immediately; the old word never appears; a fresh word afterwards completes normally.
REQ-040 The bench SHALL cover: INV_EN=0, in_inv=1, byte 0x53 -> output 0xED (forward mode), plus a randomized scoreboard of 1000 words against the FIPS-197 tables.
